// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the register-file write request.
package rv_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_req_t;

endpackage

// File: rtl/wb_buf_fifo.sv
// Small FIFO of long-latency results with a per-entry valid bit that can be
// cleared by destination-register match (WAW squash) while the entry waits.
module wb_buf_fifo
  import rv_pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              push_valid_i,
  input  logic [REG_AW-1:0] push_rd_i,
  input  logic [XLEN-1:0]   push_data_i,
  input  logic              pop_i,
  input  logic              squash_en_i,
  input  logic [REG_AW-1:0] squash_rd_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_valid_o,
  output logic [REG_AW-1:0] head_rd_o,
  output logic [XLEN-1:0]   head_data_o,
  output logic [CW-1:0]     count_o
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en_i && (rd_q[i] == squash_rd_i)) valid_d[i] = 1'b0;
    end
    if (pop_ok)  valid_d[rd_ptr_q] = 1'b0;
    if (push_ok) valid_d[wr_ptr_q] = push_valid_i;
  end

  // NOTE: state uses non-blocking assignments and async reset; only control state is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_valid_o = !empty_o && valid_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// buffered long-latency results; pipeline wins, a starvation timer requests bubbles.
module wb_port_arbiter
  import rv_pipe_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   write_back_result,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wd,
  output logic [CW-1:0]     buf_count
);

  localparam int              WCW       = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(STARVE_LIMIT - 1);

  logic              pipe_wr, lu_push, lu_store_valid, pop, blocked;
  logic              full, empty, head_valid;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              stall_req_q, stall_req_d;
  rf_wr_req_t        rf_req;

  assign pipe_wr  = RegWriteW && (RdW != '0);
  assign lu_ready = !full;
  assign lu_push  = lu_valid && lu_ready;
  // A beat aimed at x0, or overtaken by a same-cycle pipeline write to its rd, is kept only to complete the handshake.
  assign lu_store_valid = (lu_rd != '0) && !(pipe_wr && (lu_rd == RdW));
  assign pop      = !pipe_wr && !empty;
  assign blocked  = head_valid && pipe_wr;

  wb_buf_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (lu_push),
    .push_valid_i (lu_store_valid),
    .push_rd_i    (lu_rd),
    .push_data_i  (lu_data),
    .pop_i        (pop),
    .squash_en_i  (pipe_wr),
    .squash_rd_i  (RdW),
    .full_o       (full),
    .empty_o      (empty),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (buf_count)
  );

  always_comb begin
    rf_req = '0;
    if (!rst) begin
      if (pipe_wr)         rf_req = '{we: 1'b1, rd: RdW, data: write_back_result};
      else if (head_valid) rf_req = '{we: 1'b1, rd: head_rd, data: head_data};
    end
  end

  assign rf_we = rf_req.we;
  assign rf_rd = rf_req.rd;
  assign rf_wd = rf_req.data;

  // The timer saturates at its last value; stall_req then holds until the head leaves.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    stall_req_d = stall_req_q;
    if (pop || empty) begin
      wait_cnt_d  = '0;
      stall_req_d = 1'b0;
    end else if (blocked) begin
      if (wait_cnt_q == WAIT_LAST) stall_req_d = 1'b1;
      else                         wait_cnt_d  = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      stall_req_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign stall_req = stall_req_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] write_back_result;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready, stall_req, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  buf_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] shadow [32];

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .RegWriteW         (RegWriteW),
    .RdW               (RdW),
    .write_back_result (write_back_result),
    .lu_valid          (lu_valid),
    .lu_rd             (lu_rd),
    .lu_data           (lu_data),
    .lu_ready          (lu_ready),
    .stall_req         (stall_req),
    .rf_we             (rf_we),
    .rf_rd             (rf_rd),
    .rf_wd             (rf_wd),
    .buf_count         (buf_count)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rdw;
    logic [31:0] wbr;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_stall;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rw, input logic [4:0] rdw, input logic [31:0] wbr,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd,
                              input logic e_rdy, input logic e_stall, input logic [1:0] e_cnt);
    vec_t v;
    v.rw = rw; v.rdw = rdw; v.wbr = wbr; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output bundle order: {rf_we, rf_rd, rf_wd, lu_ready, stall_req, buf_count}
  task automatic apply(input vec_t v, input int idx);
    RegWriteW = v.rw; RdW = v.rdw; write_back_result = v.wbr;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ld;
    @(negedge clk);
    check($sformatf("row%0d", idx),
          {22'd0, rf_we, rf_rd, rf_wd, lu_ready, stall_req, buf_count},
          {22'd0, v.e_we, v.e_rd, v.e_wd, v.e_rdy, v.e_stall, v.e_cnt});
    if (rf_we) shadow[rf_rd] = rf_wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    //          rw rdw wbr           lv lrd ld            we rd  wd            rdy st cnt
    vecs[0]  = mk(0, 0, 32'h0,       1, 5,  32'hA5,       0, 0,  32'h0,        1, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,       0, 0,  32'h0,        1, 5,  32'hA5,       1, 0, 1);
    vecs[2]  = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[3]  = mk(1, 3, 32'h11,      1, 7,  32'h77,       1, 3,  32'h11,       1, 0, 0);
    vecs[4]  = mk(1, 3, 32'h11,      0, 0,  32'h0,        1, 3,  32'h11,       1, 0, 1);
    vecs[5]  = mk(1, 3, 32'h11,      0, 0,  32'h0,        1, 3,  32'h11,       1, 0, 1);
    vecs[6]  = mk(1, 3, 32'h11,      0, 0,  32'h0,        1, 3,  32'h11,       1, 0, 1);
    vecs[7]  = mk(1, 3, 32'h11,      0, 0,  32'h0,        1, 3,  32'h11,       1, 0, 1);
    vecs[8]  = mk(1, 3, 32'h11,      0, 0,  32'h0,        1, 3,  32'h11,       1, 1, 1);
    vecs[9]  = mk(0, 0, 32'h0,       0, 0,  32'h0,        1, 7,  32'h77,       1, 1, 1);
    vecs[10] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[11] = mk(1, 3, 32'h22,      1, 8,  32'h88,       1, 3,  32'h22,       1, 0, 0);
    vecs[12] = mk(1, 3, 32'h22,      1, 9,  32'h99,       1, 3,  32'h22,       1, 0, 1);
    vecs[13] = mk(1, 3, 32'h22,      1, 10, 32'hAA,       1, 3,  32'h22,       0, 0, 2);
    vecs[14] = mk(0, 0, 32'h0,       1, 10, 32'hAA,       1, 8,  32'h88,       0, 0, 2);
    vecs[15] = mk(0, 0, 32'h0,       1, 10, 32'hAA,       1, 9,  32'h99,       1, 0, 1);
    vecs[16] = mk(0, 0, 32'h0,       0, 0,  32'h0,        1, 10, 32'hAA,       1, 0, 1);
    vecs[17] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[18] = mk(0, 0, 32'h0,       1, 4,  32'h1,        0, 0,  32'h0,        1, 0, 0);
    vecs[19] = mk(1, 4, 32'h2,       0, 0,  32'h0,        1, 4,  32'h2,        1, 0, 1);
    vecs[20] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 1);
    vecs[21] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[22] = mk(1, 6, 32'h66,      1, 6,  32'hBAD,      1, 6,  32'h66,       1, 0, 0);
    vecs[23] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 1);
    vecs[24] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[25] = mk(0, 0, 32'h0,       1, 0,  32'hDEAD,     0, 0,  32'h0,        1, 0, 0);
    vecs[26] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 1);
    vecs[27] = mk(1, 0, 32'h55,      0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);
    vecs[28] = mk(0, 0, 32'h0,       0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0);

    // Reset held with an LU beat presented: nothing may be accepted or written.
    rst = 1'b1;
    RegWriteW = 1'b0; RdW = '0; write_back_result = '0;
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {22'd0, rf_we, rf_rd, rf_wd, lu_ready, stall_req, buf_count},
          {22'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    check("x4_keeps_pipe_value", {32'd0, shadow[4]},  64'h2);
    check("x6_keeps_pipe_value", {32'd0, shadow[6]},  64'h66);
    check("x7_drained",          {32'd0, shadow[7]},  64'h77);
    check("x10_held_beat",       {32'd0, shadow[10]}, 64'hAA);
    check("x0_never_written",    {32'd0, shadow[0]},  64'h0);

    // Fill both entries under pipeline writes, then reset asynchronously mid-cycle.
    RegWriteW = 1'b1; RdW = 5'd3; write_back_result = 32'h33;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hB1;
    @(posedge clk); #1;
    lu_rd = 5'd12; lu_data = 32'hB2;
    @(posedge clk); #1;
    lu_valid = 1'b0;
    @(negedge clk);
    check("full_before_rst", {62'd0, lu_ready, buf_count[1]}, {62'd0, 1'b0, 1'b1});
    #1 rst = 1'b1;
    #1;
    check("async_rst_count", {62'd0, buf_count}, 64'd0);
    check("async_rst_ready_stall_we", {61'd0, lu_ready, stall_req, rf_we}, {61'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0; RegWriteW = 1'b0; RdW = '0;
    @(negedge clk);
    check("post_rst_no_write", {61'd0, rf_we, buf_count}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_idle", {61'd0, rf_we, buf_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
